// File: rtl/cpu_pkg.sv
// Shared CPU execute-stage definitions: shift op / shift FSM state encodings
// and the ALU opcodes used by decode.
package cpu_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_ROR = 2'b10,
    SH_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SHIFT = 4'd7
  } alu_op_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 1 or 4 bit positions for the iterative
// shift sequencer.
module shift_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  shift_op_e        op,
  input  logic             step4,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] stepped
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    stepped = data;
    case (op)
      SH_SLL: stepped = step4 ? (data << 4) : (data << 1);
      SH_SRL: stepped = step4 ? (data >> 4) : (data >> 1);
      SH_SRA: stepped = step4 ? WIDTH'($signed(data) >>> 4) : WIDTH'($signed(data) >>> 1);
      SH_ROR: stepped = step4 ? {data[3:0], data[WIDTH-1:4]} : {data[0], data[WIDTH-1:1]};
      default: stepped = data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: one bit per cycle, or four bits per cycle
// while the remaining count is >= 4 when SHIFT_FAST_EN is defined.
module shift_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             amt_sel,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] shamt,
  input  logic [WIDTH-1:0] rs_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  shift_state_e     state, state_next;
  shift_op_e        op_q;
  logic [WIDTH-1:0] work, step_out, result_q;
  logic [AMT_W-1:0] cnt, amt, step_sz, cnt_dec;
  logic             step4, accept;

  assign amt    = amt_sel ? rs_val[AMT_W-1:0] : shamt;
  assign accept = start && (state == ST_IDLE || state == ST_DONE);

`ifdef SHIFT_FAST_EN
  assign step4 = (cnt >= AMT_W'(4));
`else
  assign step4 = 1'b0;
`endif

  assign step_sz = step4 ? AMT_W'(4) : AMT_W'(1);
  assign cnt_dec = cnt - step_sz;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .step4   (step4),
    .data    (work),
    .stepped (step_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept)                state_next = (amt == '0) ? ST_DONE : ST_SHIFT;
        else if (state == ST_DONE) state_next = ST_IDLE;
      end
      ST_SHIFT: if (cnt_dec == '0) state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Working register, counter and result; result only moves on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      op_q     <= SH_SLL;
      cnt      <= '0;
      result_q <= '0;
    end else if (accept) begin
      work <= data_in;
      op_q <= shift_op_e'(op);
      cnt  <= amt;
      if (amt == '0) result_q <= data_in;
    end else if (state == ST_SHIFT) begin
      work <= step_out;
      cnt  <= cnt_dec;
      if (cnt_dec == '0) result_q <= step_out;
    end
  end

  always_comb begin
    busy = (state == ST_SHIFT);
    done = (state == ST_DONE);
  end

  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer; honours SHIFT_FAST_EN for expected latency.
module tb_shift_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, amt_sel;
  logic [1:0]  op;
  logic [31:0] data_in, rs_val, result;
  logic [4:0]  shamt;
  logic        busy, done;

  typedef struct {
    logic [31:0] result;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   busy_cnt = 0;
  int   done_seen = 0;

  shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .amt_sel (amt_sel),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .rs_val  (rs_val),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int n_of(input logic [4:0] a);
`ifdef SHIFT_FAST_EN
    return int'(a) / 4 + int'(a) % 4;
`else
    return int'(a);
`endif
  endfunction

  // Called at a negedge; returns at the negedge of cycle 1 with inputs scrambled.
  task automatic issue(input logic [1:0] o, input logic sel, input logic [31:0] d,
                       input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] exp_res, input logic push);
    exp_t it;
    op = o; amt_sel = sel; data_in = d; shamt = sh; rs_val = rs; start = 1'b1;
    if (push) begin
      it.result = exp_res;
      it.acc    = cyc;
      it.lat    = n_of(sel ? rs[4:0] : sh) + 1;
      sb.push_back(it);
    end
    @(negedge clk);
    start = 1'b0; op = ~o; amt_sel = ~sel; data_in = ~d; shamt = ~sh; rs_val = ~rs;
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !busy && !done) break;
      @(negedge clk);
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("done_seen", done, 1'b1);
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t it;
    if (busy && done) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b, expected not both (cycle %0d)", busy, done, cyc);
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_seen++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding, expected 0 (cycle %0d)", cyc);
      end else begin
        it = sb.pop_front();
        check("result", result, it.result);
        check("latency", cyc - it.acc, it.lat);
        check("busy_cycles", busy_cnt, it.lat - 1);
      end
      busy_cnt = 0;
    end
    if (!busy && !done) busy_cnt = 0;
  end

  initial begin
    rst = 1'b1; start = 1'b0; amt_sel = 1'b0; op = 2'b00;
    data_in = '0; shamt = '0; rs_val = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(SH_SLL, 1'b0, 32'h0000_0001, 5'd4, 32'h0, 32'h0000_0010, 1'b1); wait_quiet();
    issue(SH_SRA, 1'b1, 32'h8000_0000, 5'd0, 32'hFFFF_FFE3, 32'hF000_0000, 1'b1); wait_quiet();
    issue(SH_SRL, 1'b0, 32'h1234_5678, 5'd0, 32'h0, 32'h1234_5678, 1'b1); wait_quiet();
    issue(SH_SRL, 1'b0, 32'h8000_0000, 5'd31, 32'h0, 32'h0000_0001, 1'b1); wait_quiet();
    issue(SH_SLL, 1'b1, 32'h0000_0001, 5'd2, 32'h0000_003F, 32'h8000_0000, 1'b1); wait_quiet();
    issue(SH_ROR, 1'b0, 32'h0000_001F, 5'd5, 32'h0, 32'hF800_0000, 1'b1); wait_quiet();
    issue(SH_SRA, 1'b0, 32'h7FFF_FFFF, 5'd7, 32'h0, 32'h00FF_FFFF, 1'b1); wait_quiet();

    // ror by 8, a stray start mid-shift, then back-to-back start in the DONE cycle
    issue(SH_ROR, 1'b0, 32'h1234_5678, 5'd8, 32'h0, 32'h7812_3456, 1'b1);
    @(negedge clk);
    issue(SH_SLL, 1'b0, 32'hFFFF_FFFF, 5'd3, 32'h0, 32'h0, 1'b0);
    wait_done();
    issue(SH_SLL, 1'b0, 32'h0000_0001, 5'd1, 32'h0, 32'h0000_0002, 1'b1);
    wait_quiet();

    // reset during cycle 3 of a 10-bit shift aborts with no done
    issue(SH_SRL, 1'b0, 32'hFFFF_0000, 5'd10, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 32'h0);
    rst = 1'b0;
    begin
      int base;
      base = done_seen;
      repeat (15) @(negedge clk);
      check("no_done_after_rst", done_seen, base);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the CPU execute stage. It takes a shift request, selects the shift amount from either the instruction `shamt` field or the low five bits of a register operand, and sequences an iterative one-bit-per-cycle shift, with an optional four-bit fast step. The pipeline stalls on `busy` and captures `result` on the `done` pulse. This replaces a full barrel shifter with a small datapath plus counter.

## Interface
- `WIDTH`, 32: data width.
- `AMT_W`, 5: shift-amount width; the maximum shift is 2^AMT_W-1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE or DONE.
- `amt_sel`  in  1  0 = use `shamt`; 1 = use `rs_val[AMT_W-1:0]`.
- `op`  in  2  00 sll, 01 srl, 10 ror, 11 sra.
- `data_in`  in  WIDTH  operand to shift.
- `shamt`  in  AMT_W  immediate shift amount.
- `rs_val`  in  WIDTH  register operand; only low AMT_W bits are used.
- `busy`  out  1  high while shifting; the pipeline stalls on it.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  WIDTH  shifted value; held until the next accepted `start`.

## Operation
- States are IDLE, SHIFT and DONE.
- **IDLE or DONE with `start`=1:**
  - Latch `data_in` and `op`.
  - Latch amount `cnt` = `amt_sel ? rs_val[AMT_W-1:0] : shamt`.
  - If `cnt`==0, go to DONE with `result`=`data_in`. Otherwise go to SHIFT.
- **DONE without `start`:** go to IDLE.
- **SHIFT:** each cycle, apply one step to the working register and decrement `cnt` by the step size. When `cnt` reaches 0, go to DONE.
- Step semantics, per bit:
  - sll: insert 0 at LSB.
  - srl: insert 0 at MSB.
  - sra: replicate bit WIDTH-1.
  - ror: bit 0 moves to MSB.
- `start` is ignored in SHIFT; no queueing.
- `op` and `amt_sel` are sampled only at acceptance. Changes afterward have no effect.
- `result` updates only on entry to DONE, so intermediate values are never visible.
- `rst`: state→IDLE, `busy`=0, `done`=0, `result`=0, `cnt`=0.
  - Reset mid-shift aborts with no `done` pulse.
  - `rst` has priority over `start` in the same cycle.

## Timing
- Cycle 0 is the `start` acceptance cycle.
- `busy` is high in cycles 1..N and `done` is high in cycle N+1, where N is the number of shift cycles.
- Default N equals the shift amount (0..31). Amount 0 gives `done` in cycle 1 with `busy` never high.
- `busy` and `done` are never high together.
- Back-to-back: `start` accepted in the DONE cycle begins a new operation. `done` falls the next cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SHIFT_FAST_EN` defined:
  - The step is 4 bits when `cnt`>=4, otherwise 1 bit.
  - N = floor(amt/4) + (amt mod 4).
  - Functional results are identical to the default build.
- `SHIFT_FAST_EN` undefined: the step is always 1 bit; N = amt.

## Structure
- The shared package `cpu_pkg` holds:
  - The `op` encodings `SH_SLL`, `SH_SRL`, `SH_ROR`, `SH_SRA`.
  - The state encodings `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
  - The ALU opcodes already used by decode.
- One combinational sub-module, `shift_step`: inputs are `op`, a step-of-4 flag and the data word; the output is the stepped word.
- The FSM, counter, amount mux and result register live in `shift_sequencer`.

## Test plan
- sll, `amt_sel`=0, `shamt`=4, `data_in`=0x00000001 → `busy` cycles 1-4, `done` cycle 5, `result`=0x00000010.
- sra, `amt_sel`=1, `rs_val`=0xFFFFFFE3 (amt 3), `data_in`=0x80000000 → `done` cycle 4, `result`=0xF0000000.
- srl, `shamt`=0, `data_in`=0x12345678 → `done` cycle 1, `busy` never high, `result`=0x12345678.
- ror, `shamt`=8, `data_in`=0x12345678 → `result`=0x78123456. `done` in cycle 9 by default; cycle 3 with `SHIFT_FAST_EN`.
- `start` with a different op during SHIFT is ignored. A second `start` (sll by 1 of 0x1) in the DONE cycle is accepted → `done` two cycles later with `result`=0x00000002.
- `rst` asserted in cycle 3 of a 10-bit shift → next cycle `busy`=0, `done`=0, `result`=0. No `done` pulse follows.
